// File: rtl/xyolo_databus_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : xyolo_databus_resp_if
// Purpose  : Multi-port databus bundle between initiators and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface xyolo_databus_resp_if #(
  parameter int DATABUS_W = 256,
  parameter int IO_ADDR_W = 32,
  parameter int N_PORTS   = 2
);
  logic [N_PORTS-1:0]             databus_valid;
  logic [N_PORTS*IO_ADDR_W-1:0]   databus_addr;
  logic [N_PORTS*DATABUS_W-1:0]   databus_wdata;
  logic [N_PORTS*DATABUS_W/8-1:0] databus_wstrb;
  logic [N_PORTS-1:0]             databus_ready;
  logic [N_PORTS*DATABUS_W-1:0]   databus_rdata;
  logic                           busy;

  modport master (
    output databus_valid, databus_addr, databus_wdata, databus_wstrb,
    input  databus_ready, databus_rdata, busy
  );

  modport slave (
    input  databus_valid, databus_addr, databus_wdata, databus_wstrb,
    output databus_ready, databus_rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/xyolo_databus_resp.sv
`default_nettype none
// ============================================================================
// Module   : xyolo_databus_resp
// Purpose  : Round-robin multi-port responder in front of a single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module xyolo_databus_resp #(
  parameter int DATABUS_W  = 256,
  parameter int IO_ADDR_W  = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int N_PORTS    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  xyolo_databus_resp_if.slave  bus
);

  localparam int c_BYTES = DATABUS_W / 8;
  localparam int c_OFF_W = $clog2(c_BYTES);
  localparam int c_PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int c_DEPTH = 2 ** MEM_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_PW-1:0]         r_rr_ptr;
  logic [c_PW-1:0]         r_gnt;
  logic [MEM_ADDR_W-1:0]   r_word;
  logic [DATABUS_W-1:0]    r_wdata;
  logic [c_BYTES-1:0]      r_wstrb;

  logic                    w_any;
  logic                    w_found;
  logic [c_PW:0]           w_sum;
  logic [c_PW-1:0]         w_idx;
  logic [c_PW-1:0]         w_gnt;
  logic [c_PW-1:0]         w_ptr_nxt;
  logic [IO_ADDR_W-1:0]    w_sel_addr;
  logic [DATABUS_W-1:0]    w_sel_wdata;
  logic [c_BYTES-1:0]      w_sel_wstrb;
  logic                    w_is_write;
  logic                    w_unused_addr_bits;

  logic [DATABUS_W-1:0]    r_mem [c_DEPTH];
  logic [DATABUS_W-1:0]    r_rd_word;

  assign w_any      = |bus.databus_valid;
  assign w_is_write = |r_wstrb;
  assign bus.busy   = (r_state != ST_IDLE);

  // Search begins at r_rr_ptr and wraps, so the first hit is the RR winner.
  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    w_gnt   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_PW+1)'(i);
      if (w_sum >= (c_PW+1)'(N_PORTS)) begin
        w_sum = w_sum - (c_PW+1)'(N_PORTS);
      end
      w_idx = w_sum[c_PW-1:0];
      if (!w_found && bus.databus_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == c_PW'(N_PORTS - 1)) ? '0 : (w_gnt + 1'b1);

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_gnt == c_PW'(p)) begin
        w_sel_addr  = bus.databus_addr[p*IO_ADDR_W +: IO_ADDR_W];
        w_sel_wdata = bus.databus_wdata[p*DATABUS_W +: DATABUS_W];
        w_sel_wstrb = bus.databus_wstrb[p*c_BYTES +: c_BYTES];
      end
    end
  end

  // Byte offset and bits above the word index are dropped on purpose (wrap).
  assign w_unused_addr_bits = ^w_sel_addr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) begin
        r_gnt    <= w_gnt;
        r_rr_ptr <= w_ptr_nxt;
        r_word   <= w_sel_addr[c_OFF_W +: MEM_ADDR_W];
        r_wdata  <= w_sel_wdata;
        r_wstrb  <= w_sel_wstrb;
      end
    end
  end

  // Storage is deliberately not reset; the read register only matters in RESP.
  always_ff @(posedge clk) begin
    if (r_state == ST_ACCESS) begin
      if (w_is_write) begin
        for (int b = 0; b < c_BYTES; b++) begin
          if (r_wstrb[b]) begin
            r_mem[r_word][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
      r_rd_word <= r_mem[r_word];
    end
  end

  always_comb begin
    bus.databus_ready = '0;
    bus.databus_rdata = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (r_state == ST_RESP && r_gnt == c_PW'(p)) begin
        bus.databus_ready[p] = 1'b1;
        if (!w_is_write) begin
          bus.databus_rdata[p*DATABUS_W +: DATABUS_W] = r_rd_word;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xyolo_databus_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_xyolo_databus_resp
// Purpose  : Directed vector bench for the round-robin databus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xyolo_databus_resp;

  localparam int c_DW = 256;
  localparam int c_AW = 32;
  localparam int c_MW = 10;
  localparam int c_NP = 2;
  localparam int c_BW = c_DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xyolo_databus_resp_if #(.DATABUS_W(c_DW), .IO_ADDR_W(c_AW), .N_PORTS(c_NP)) bus ();

  xyolo_databus_resp #(
    .DATABUS_W(c_DW), .IO_ADDR_W(c_AW), .MEM_ADDR_W(c_MW), .N_PORTS(c_NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               port;
    logic [c_AW-1:0]  addr;
    logic [c_DW-1:0]  wdata;
    logic [c_BW-1:0]  wstrb;
    logic [c_DW-1:0]  exp;
  } vec_t;

  vec_t tbl[10];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One transaction: returns latency in edges, the read word, and whether the
  // other port ever saw ready.  Inputs are scrambled after the grant edge.
  task automatic do_txn(input int port, input logic [c_AW-1:0] addr,
                        input logic [c_DW-1:0] wdata, input logic [c_BW-1:0] wstrb,
                        output logic [c_DW-1:0] rd, output int lat, output bit stray);
    bit got;
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    bus.databus_valid[port]               = 1'b1;
    bus.databus_addr[port*c_AW +: c_AW]   = addr;
    bus.databus_wdata[port*c_DW +: c_DW]  = wdata;
    bus.databus_wstrb[port*c_BW +: c_BW]  = wstrb;
    lat = 0; got = 1'b0; stray = 1'b0; rd = '0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.databus_addr[port*c_AW +: c_AW]  = ~addr;
        bus.databus_wdata[port*c_DW +: c_DW] = ~wdata;
        bus.databus_wstrb[port*c_BW +: c_BW] = ~wstrb;
      end
      if ((bus.databus_ready & ~(c_NP'(1) << port)) != '0) stray = 1'b1;
      if (bus.databus_ready[port]) begin
        got = 1'b1;
        rd  = bus.databus_rdata[port*c_DW +: c_DW];
      end
    end
    bus.databus_valid[port] = 1'b0;
    bus.databus_wstrb       = '0;
  endtask

  logic [c_DW-1:0] rd;
  int              lat;
  bit              stray;

  initial begin
    logic [c_DW-1:0] pat_a5, pat_lo_ff, pat_mix, pat_x;
    int  order[$];
    bit  both;
    int  first_port;

    pat_a5    = {32{8'hA5}};
    pat_lo_ff = {{28{8'h00}}, {4{8'hFF}}};
    pat_mix   = {{4{8'h3C}}, {28{8'hA5}}};
    pat_x     = {8{32'h1234_5678}};

    tbl[0] = '{0, 32'h0000_0040, pat_a5,       32'hFFFF_FFFF, '0};
    tbl[1] = '{0, 32'h0000_0040, '0,           32'h0000_0000, pat_a5};
    tbl[2] = '{1, 32'h0000_0020, '0,           32'hFFFF_FFFF, '0};
    tbl[3] = '{1, 32'h0000_0020, {32{8'hFF}},  32'h0000_000F, '0};
    tbl[4] = '{1, 32'h0000_0020, '0,           32'h0000_0000, pat_lo_ff};
    tbl[5] = '{0, 32'h0000_8000, pat_x,        32'hFFFF_FFFF, '0};
    tbl[6] = '{1, 32'h0000_0000, '0,           32'h0000_0000, pat_x};
    tbl[7] = '{0, 32'h0000_005F, '0,           32'h0000_0000, pat_a5};
    tbl[8] = '{1, 32'h0000_0040, {32{8'h3C}},  32'hF000_0000, '0};
    tbl[9] = '{0, 32'h0000_0040, '0,           32'h0000_0000, pat_mix};

    bus.databus_valid = '0;
    bus.databus_addr  = '0;
    bus.databus_wdata = '0;
    bus.databus_wstrb = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  c_DW'(bus.busy), '0);
    check("reset_ready", c_DW'(bus.databus_ready), '0);
    check("reset_rdata", c_DW'(|bus.databus_rdata), '0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      do_txn(tbl[v].port, tbl[v].addr, tbl[v].wdata, tbl[v].wstrb, rd, lat, stray);
      check($sformatf("vec%0d_latency", v), c_DW'(lat), c_DW'(2));
      check($sformatf("vec%0d_rdata", v), rd, tbl[v].exp);
      check($sformatf("vec%0d_other_ready", v), c_DW'(stray), '0);
    end

    // Both ports hold valid: grants must alternate starting from port 0.
    @(negedge clk); while (bus.busy) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.databus_addr  = {32'h0000_0020, 32'h0000_0040};
    bus.databus_wstrb = '0;
    bus.databus_valid = 2'b11;
    both = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      if (bus.databus_ready == 2'b11) both = 1'b1;
      else if (bus.databus_ready[0]) order.push_back(0);
      else if (bus.databus_ready[1]) order.push_back(1);
    end
    @(negedge clk); bus.databus_valid = '0;
    check("rr_count", c_DW'(order.size()), c_DW'(6));
    for (int k = 0; k < 6; k++) begin
      if (k < order.size()) check($sformatf("rr_grant%0d", k), c_DW'(order[k]), c_DW'(k % 2));
    end
    check("rr_both_ready", c_DW'(both), '0);

    // Reset during ACCESS of a port-0 read aborts it silently.
    @(negedge clk); while (bus.busy) @(negedge clk);
    bus.databus_addr[0 +: c_AW] = 32'h0000_0040;
    bus.databus_valid[0]        = 1'b1;
    @(posedge clk); #1;
    check("abort_in_access", c_DW'(bus.busy), c_DW'(1));
    @(negedge clk); rst = 1'b1; #1;
    check("abort_busy",  c_DW'(bus.busy), '0);
    check("abort_ready", c_DW'(bus.databus_ready), '0);
    check("abort_rdata", c_DW'(|bus.databus_rdata), '0);
    @(negedge clk); rst = 1'b0; bus.databus_valid = '0;
    stray = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.databus_ready != '0) stray = 1'b1;
    end
    check("abort_no_late_ready", c_DW'(stray), '0);
    do_txn(1, 32'h0000_0020, '0, '0, rd, lat, stray);
    check("after_abort_p1_latency", c_DW'(lat), c_DW'(2));
    check("after_abort_p1_rdata", rd, pat_lo_ff);
    check("after_abort_p1_other", c_DW'(stray), '0);

    // Pointer must return to port 0 on reset even after a port-0 grant.
    do_txn(0, 32'h0000_0040, '0, '0, rd, lat, stray);
    @(negedge clk); while (bus.busy) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.databus_valid = 2'b11;
    first_port = -1;
    for (int c = 0; c < 10 && first_port < 0; c++) begin
      @(posedge clk); #1;
      if (bus.databus_ready[0]) first_port = 0;
      else if (bus.databus_ready[1]) first_port = 1;
    end
    bus.databus_valid = '0;
    check("rst_ptr_first_grant", c_DW'(first_port), '0);

    // Quiet bus.
    @(negedge clk); while (bus.busy) @(negedge clk);
    stray = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.busy || bus.databus_ready != '0 || bus.databus_rdata != '0) stray = 1'b1;
    end
    check("idle_100_quiet", c_DW'(stray), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xyolo_databus_resp.md
XYOLO_DATABUS_RESP -- requirements
Module: xyolo_databus_resp

Interface
- REQ-001: Parameter DATABUS_W, default 256: databus data width in bits; a multiple of 8.
- REQ-002: Parameter IO_ADDR_W, default 32: byte-address width per port.
- REQ-003: Parameter MEM_ADDR_W, default 10: word-address width of the internal memory (2^MEM_ADDR_W words of DATABUS_W bits).
- REQ-004: Parameter N_PORTS, default 2: number of initiator ports served.
- REQ-005: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-006: rst  input  1  reset, asynchronous, active-high.
- REQ-007: databus_valid  input  N_PORTS  per-port request strobe; the initiator holds it until it sees ready.
- REQ-008: databus_addr  input  N_PORTS*IO_ADDR_W  per-port byte address; port p occupies slice p.
- REQ-009: databus_wdata  input  N_PORTS*DATABUS_W  per-port write data.
- REQ-010: databus_wstrb  input  N_PORTS*DATABUS_W/8  per-port byte enables; all-zero means read.
- REQ-011: databus_ready  output  N_PORTS  per-port completion pulse.
- REQ-012: databus_rdata  output  N_PORTS*DATABUS_W  per-port read data.
- REQ-013: busy  output  1  high whenever the FSM is not in IDLE.

Function
- REQ-014: Word index = addr[MEM_ADDR_W+log2(DATABUS_W/8)-1 : log2(DATABUS_W/8)]; lower byte-offset bits and bits above the word index are ignored, so out-of-range addresses wrap.
- REQ-015: FSM states: IDLE, ACCESS, RESP; transitions IDLE->ACCESS when any valid is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
- REQ-016: In IDLE with at least one valid high, one port is granted, and its index, word address, wdata and wstrb are latched at the same edge.
- REQ-017: Arbitration is round-robin: the search starts at the port after the last granted port and wraps modulo N_PORTS; after reset the search starts at port 0.
- REQ-018: In ACCESS the latched operation goes to memory: on a write, byte b is updated iff wstrb[b], bits [8b+7:8b]; on a read, the addressed word is read with 1-cycle RAM latency.
- REQ-019: In RESP the granted port's databus_ready is 1 for exactly one cycle; on a read, its databus_rdata carries the word; on a write, it is 0.
- REQ-020: The latency from the first IDLE cycle with valid high to ready is 2 cycles; the maximum throughput is one transaction per 3 cycles.
- REQ-021: At all other times every databus_ready bit is 0 and every databus_rdata slice is 0; non-granted ports never see ready.
- REQ-022: Valid on a port must not be dropped before that port's ready; the value of valid, addr, wdata and wstrb after the grant edge does not affect the current transaction.
- REQ-023: A port whose valid is still high in the IDLE cycle after its RESP is treated as a new request.
- REQ-024: A read after a write to the same word returns the updated data (the write completes in ACCESS, before any later read's ACCESS).
- REQ-025: Simultaneous valids on all ports are each served within N_PORTS transactions (no starvation).

Reset
- REQ-026: While rst is high: FSM=IDLE, databus_ready=0, databus_rdata=0, busy=0, round-robin pointer=port 0, latched request cleared.
- REQ-027: rst asserted mid-transaction aborts it with no ready; a write aborted in ACCESS may or may not have updated memory.
- REQ-028: Memory contents are not initialised by reset.

Verification
- REQ-029: Port0 writes 0xA5 repeated, addr 0x40, wstrb all ones; then reads addr 0x40 -> ready on port0 2 cycles after each valid; read rdata = all 0xA5 bytes.
- REQ-030: Word holds all 0x00; port1 writes addr 0x20 with wdata all 0xFF, wstrb=0x0000000F -> a subsequent read returns 0xFF in bytes 0-3 and 0x00 elsewhere.
- REQ-031: Ports 0 and 1 both hold valid continuously for 6 requests -> grants alternate 0,1,0,1,0,1; ready is never high on both in one cycle.
- REQ-032: With MEM_ADDR_W=10, write addr 0x8000 then read addr 0x0 -> same word returned (wrap).
- REQ-033: rst pulsed in ACCESS of a port0 read -> no ready; outputs 0; the next request to port1 is granted first.
- REQ-034: Idle bus for 100 cycles -> busy=0, ready=0, rdata=0 throughout.
